// File: rtl/handshake_constant_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_constant_seq_if
//  Description : Valid/ready channel bundle for the constant-sequence source.
//                One control channel comes in (data-less token) and one data
//                channel goes out.
//  Signals     : ctrl_valid  - control token offered (master -> slave)
//                ctrl_ready  - control token accepted (slave -> master)
//                outs        - current constant (slave -> master)
//                outs_last   - outs is the final table entry (slave -> master)
//                outs_valid  - output token present (slave -> master)
//                outs_ready  - consumer accepts output (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface handshake_constant_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  ctrl_valid;
   logic                  ctrl_ready;
   logic [DATA_WIDTH-1:0] outs;
   logic                  outs_last;
   logic                  outs_valid;
   logic                  outs_ready;

   // Environment side: offers control tokens, consumes constants.
   modport master (
      output ctrl_valid,
      input  ctrl_ready,
      input  outs,
      input  outs_last,
      input  outs_valid,
      output outs_ready
   );

   // Constant source side.
   modport slave (
      input  ctrl_valid,
      output ctrl_ready,
      output outs,
      output outs_last,
      output outs_valid,
      input  outs_ready
   );
endinterface
`default_nettype wire

// File: rtl/handshake_constant_seq.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_constant_seq
//  Description : Dataflow constant source. Each accepted control token loads
//                the next entry of a parametrised constant table into a
//                one-slot registered output buffer. The index either wraps
//                to entry 0 or saturates on the last entry.
//  Ports       : clk - rising-edge clock
//                rst - synchronous active-high reset
//                hs  - slave view of the control/output handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_constant_seq #(
   parameter int                            DATA_WIDTH = 32,
   parameter int                            DEPTH      = 4,
   parameter logic [DEPTH*DATA_WIDTH-1:0]   VALUES     = '0,
   parameter int                            WRAP       = 1
) (
   input  wire logic               clk,
   input  wire logic               rst,
   handshake_constant_seq_if.slave hs
);

   localparam int                IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(DEPTH - 1);

   logic [IDX_W-1:0]      r_idx;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_last;

   logic                  w_ctrl_ready;
   logic                  w_load;
   logic                  w_at_last;
   logic [DATA_WIDTH-1:0] w_entry;
   logic [IDX_W-1:0]      w_idx_next;

   // The slot can take a new token when empty or when it drains this cycle;
   // this is the only combinational path and it comes from outs_ready alone.
   assign w_ctrl_ready = !r_full || hs.outs_ready;
   assign w_load       = hs.ctrl_valid && w_ctrl_ready;
   assign w_at_last    = (r_idx == c_LAST_IDX);

   // Table lookup as a compare-and-select mux so no index past DEPTH-1 is
   // ever formed, even when DEPTH is not a power of two.
   always_comb begin
      w_entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_entry = VALUES[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Wrap/saturate resolved in the load cycle, so there is no bubble at the
   // end of the table. With DEPTH == 1 both branches yield 0.
   always_comb begin
      w_idx_next = r_idx + 1'b1;
      if (w_at_last) begin
         w_idx_next = (WRAP != 0) ? '0 : c_LAST_IDX;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx  <= '0;
         r_full <= 1'b0;
         r_data <= '0;
         r_last <= 1'b0;
      end else if (w_load) begin
         // A load during a drain simply replaces the slot contents.
         r_idx  <= w_idx_next;
         r_full <= 1'b1;
         r_data <= w_entry;
         r_last <= w_at_last;
      end else if (r_full && hs.outs_ready) begin
         r_full <= 1'b0;
      end
   end

   assign hs.ctrl_ready = w_ctrl_ready;
   assign hs.outs_valid = r_full;
   assign hs.outs       = r_data;
   assign hs.outs_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_constant_seq
//  Description : Self-checking bench for handshake_constant_seq. Three
//                instances: DEPTH=3 wrapping, DEPTH=3 saturating, DEPTH=1.
//                Expected tokens are queued when a control token is accepted
//                and compared when the consumer accepts an output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_constant_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   handshake_constant_seq_if #(.DATA_WIDTH(8)) if_w ();
   handshake_constant_seq_if #(.DATA_WIDTH(8)) if_s ();
   handshake_constant_seq_if #(.DATA_WIDTH(8)) if_d ();

   handshake_constant_seq #(
      .DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h33_22_11), .WRAP(1)
   ) dut_w (.clk(clk), .rst(rst), .hs(if_w));

   handshake_constant_seq #(
      .DATA_WIDTH(8), .DEPTH(3), .VALUES(24'h33_22_11), .WRAP(0)
   ) dut_s (.clk(clk), .rst(rst), .hs(if_s));

   handshake_constant_seq #(
      .DATA_WIDTH(8), .DEPTH(1), .VALUES(8'hA5), .WRAP(1)
   ) dut_d (.clk(clk), .rst(rst), .hs(if_d));

   int n_cmp = 0;
   int n_err = 0;

   // Scoreboard: {last, data} of tokens accepted but not yet consumed.
   logic [8:0] q[$];
   int         m_idx[3];
   int         n_in;
   int         n_out;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] model_token(input int sel, input int idx);
      logic [7:0] v;
      int         depth;
      depth = (sel == 2) ? 1 : 3;
      if (sel == 2)      v = 8'hA5;
      else if (idx == 0) v = 8'h11;
      else if (idx == 1) v = 8'h22;
      else               v = 8'h33;
      return {(idx == depth - 1), v};
   endfunction

   function automatic int model_next(input int sel, input int idx);
      int depth;
      depth = (sel == 2) ? 1 : 3;
      if (idx == depth - 1) return (sel == 1) ? depth - 1 : 0;
      return idx + 1;
   endfunction

   // One clock cycle on instance sel: drive at negedge, observe 1 ns later.
   task automatic step(input int sel, input logic cv, input logic orr);
      logic       cr, ov, ol, exp_cr;
      logic [7:0] o;
      logic [8:0] e;
      @(negedge clk);
      case (sel)
         0: begin if_w.ctrl_valid = cv; if_w.outs_ready = orr; end
         1: begin if_s.ctrl_valid = cv; if_s.outs_ready = orr; end
         default: begin if_d.ctrl_valid = cv; if_d.outs_ready = orr; end
      endcase
      #1;
      case (sel)
         0: begin cr = if_w.ctrl_ready; ov = if_w.outs_valid; o = if_w.outs; ol = if_w.outs_last; end
         1: begin cr = if_s.ctrl_ready; ov = if_s.outs_valid; o = if_s.outs; ol = if_s.outs_last; end
         default: begin cr = if_d.ctrl_ready; ov = if_d.outs_valid; o = if_d.outs; ol = if_d.outs_last; end
      endcase
      exp_cr = (q.size() == 0) || orr;
      chk("ctrl_ready", 32'(cr), 32'(exp_cr));
      chk("outs_valid", 32'(ov), 32'(q.size() != 0));
      if (ov && q.size() != 0) begin
         if (orr) begin
            e = q.pop_front();
            n_out++;
         end else begin
            e = q[0];
         end
         chk(orr ? "outs" : "outs_held", 32'(o), 32'(e[7:0]));
         chk(orr ? "outs_last" : "last_held", 32'(ol), 32'(e[8]));
      end
      if (cv && exp_cr) begin
         q.push_back(model_token(sel, m_idx[sel]));
         m_idx[sel] = model_next(sel, m_idx[sel]);
         n_in++;
      end
   endtask

   // One-cycle reset; a control token is offered during it and must be ignored.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      if_w.ctrl_valid = 1'b1; if_w.outs_ready = 1'b1;
      if_s.ctrl_valid = 1'b1; if_s.outs_ready = 1'b1;
      if_d.ctrl_valid = 1'b1; if_d.outs_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      if_w.ctrl_valid = 1'b0; if_w.outs_ready = 1'b0;
      if_s.ctrl_valid = 1'b0; if_s.outs_ready = 1'b0;
      if_d.ctrl_valid = 1'b0; if_d.outs_ready = 1'b0;
      q.delete();
      for (int i = 0; i < 3; i++) m_idx[i] = 0;
      n_in  = 0;
      n_out = 0;
   endtask

   initial begin
      if_w.ctrl_valid = 1'b0; if_w.outs_ready = 1'b0;
      if_s.ctrl_valid = 1'b0; if_s.outs_ready = 1'b0;
      if_d.ctrl_valid = 1'b0; if_d.outs_ready = 1'b0;

      // 1. Reset then idle.
      do_reset();
      #1;
      chk("rst_outs_valid", 32'(if_w.outs_valid), 32'd0);
      chk("rst_outs",       32'(if_w.outs),       32'h00);
      chk("rst_outs_last",  32'(if_w.outs_last),  32'd0);
      chk("rst_ctrl_ready", 32'(if_w.ctrl_ready), 32'd1);
      chk("rst_outs_s",     32'(if_s.outs),       32'h00);
      chk("rst_outs_d",     32'(if_d.outs),       32'h00);
      step(0, 1'b0, 1'b0);
      step(0, 1'b0, 1'b0);

      // 2. Streaming, wrapping table.
      for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1);
      chk("stream_count", 32'(n_out), 32'd7);

      // 3. Saturating table.
      for (int i = 0; i < 5; i++) step(1, 1'b1, 1'b1);
      step(1, 1'b0, 1'b1);
      chk("sat_count", 32'(n_out), 32'd12);

      // 4. Back-pressure from a fresh index.
      do_reset();
      for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1);
      step(0, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1);
      step(0, 1'b0, 1'b1);
      chk("bp_count", 32'(n_out), 32'd3);

      // 5. Reset while 0x22 waits in the slot.
      do_reset();
      step(0, 1'b1, 1'b0);
      step(0, 1'b1, 1'b1);
      step(0, 1'b0, 1'b0);
      chk("pre_rst_outs", 32'(if_w.outs), 32'h22);
      do_reset();
      step(0, 1'b0, 1'b1);
      step(0, 1'b1, 1'b1);
      step(0, 1'b0, 1'b1);
      chk("post_rst_count", 32'(n_out), 32'd1);

      // 6. DEPTH=1 under random traffic.
      for (int i = 0; i < 100; i++) begin
         step(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk("d1_outstanding", 32'(n_in - n_out <= 1), 32'd1);
      end
      step(2, 1'b0, 1'b1);
      step(2, 1'b0, 1'b1);
      chk("d1_in_eq_out", 32'(n_in), 32'(n_out));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
